dmem_arbiter: RTL

- Shares the single-port 32-bit data memory between the pipeline MEM stage (CPU port) and a host/loader port (program/data load, debug readback).
- CPU has default priority. Host is protected from starvation by a bounded-wait counter.
- Issues at most one memory access per cycle. Read data is returned to the owning port after a fixed memory latency, using a tag pipeline.
- Drives cpu_stall so the pipeline freezes its MEM stage while the CPU access is not granted.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_arbiter_rd_tag_pipe.sv | 33 +++
 rtl/dmem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DMEM_ADDR_WIDTH = 20;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_SIZE       = 1024;

  // Which port owns a memory access / a returning read.
  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  // One slot of the read-return tag pipeline.
  // zero = the read was out of range and must return 0 instead of mem_rdata.
  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   zero;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: OWN_CPU, zero: 1'b0};

endpackage : dmem_pkg

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register of read tags. It tracks which port a read
// belongs to while the memory is producing its data. An asynchronous clear
// drops every read in flight.
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  // Shift tags one stage per cycle; clear every stage while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RD_TAG_IDLE;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule : rd_tag_pipe

// File: rtl/dmem_arbiter.sv
// Arbiter that shares the single-port data memory between the CPU MEM stage
// and the host/loader port. The CPU wins by default. A bounded-wait counter
// gives the host one grant after STARVE_LIMIT denied cycles. Read data comes
// back to its owner through a tag pipeline that matches the memory latency.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int MEM_SIZE     = DMEM_SIZE,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // CPU (MEM stage) port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_be,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  // Host / loader port
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic                  host_be,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  // Status
  output logic                  addr_err,
  // Data memory side
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // Statistics
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  // The starve counter must be able to hold STARVE_LIMIT itself.
  localparam int                SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  // One extra bit so a MEM_SIZE equal to 2**ADDR_WIDTH still compares.
  localparam logic [ADDR_WIDTH:0] SIZE_LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);

  // Address range check against the populated memory size.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < SIZE_LIM);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SW-1:0]         starve_q,     starve_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q,  stall_cnt_d;
  logic                  addr_err_q,   addr_err_d;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration signals
  // ---------------------------------------------------------------------------
  logic                  cpu_req_s;
  logic                  host_req_s;
  logic                  host_win_s;
  logic                  cpu_win_s;
  logic                  grant_s;
  owner_t                owner_s;
  logic                  own_we_s;
  logic                  own_be_s;
  logic [ADDR_WIDTH-1:0] own_addr_s;
  logic [DATA_WIDTH-1:0] own_wdata_s;
  logic                  in_range_s;
  rd_tag_t               tag_in_s;
  rd_tag_t               tag_out_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Requests are masked during reset so nothing reaches memory then.
  assign cpu_req_s  = cpu_req  & rst;
  assign host_req_s = host_req & rst;

  // Pick the owner: host wins when alone or once it has waited long enough.
  always_comb begin
    host_win_s = 1'b0;
    cpu_win_s  = 1'b0;
    if (host_req_s && (!cpu_req_s || (starve_q == STARVE_MAX))) begin
      host_win_s = 1'b1;
    end else begin
      cpu_win_s = cpu_req_s;
    end
    grant_s = host_win_s | cpu_win_s;
    owner_s = host_win_s ? OWN_HOST : OWN_CPU;
  end

  // Mux the owning port onto the memory bus and build the read tag.
  always_comb begin
    own_we_s    = 1'b0;
    own_be_s    = 1'b0;
    own_addr_s  = {ADDR_WIDTH{1'b0}};
    own_wdata_s = {DATA_WIDTH{1'b0}};
    if (host_win_s) begin
      own_we_s    = host_we;
      own_be_s    = host_be;
      own_addr_s  = host_addr;
      own_wdata_s = host_wdata;
    end else if (cpu_win_s) begin
      own_we_s    = cpu_we;
      own_be_s    = cpu_be;
      own_addr_s  = cpu_addr;
      own_wdata_s = cpu_wdata;
    end else begin
      own_we_s    = 1'b0;
    end
    in_range_s = addr_in_range(own_addr_s);

    // Out-of-range accesses never reach memory but reads still return a tag.
    tag_in_s.valid = grant_s & ~own_we_s;
    tag_in_s.owner = owner_s;
    tag_in_s.zero  = ~in_range_s;
  end

  assign mem_addr  = own_addr_s;
  assign mem_wdata = own_wdata_s;
  assign mem_be    = own_be_s;
  assign mem_we    = grant_s & in_range_s &  own_we_s;
  assign mem_re    = grant_s & in_range_s & ~own_we_s;

  assign host_gnt  = host_win_s;
  assign cpu_stall = cpu_req_s & ~cpu_win_s;

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  rd_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in_s),
    .tag_o (tag_out_s)
  );

  // Next-state for counters, error pulse and per-port read-data registers.
  always_comb begin
    starve_d      = starve_q;
    stall_cnt_d   = stall_cnt_q;
    addr_err_d    = grant_s & ~in_range_s;
    cpu_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    host_rdata_d  = host_rdata_q;

    // A denied host request ages; a grant or a dropped request resets it.
    if (host_req_s && !host_win_s) begin
      if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + SW'(1);
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = {SW{1'b0}};
    end

    // Count stalled CPU cycles, sticking at all-ones.
    if (cpu_stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    rd_word_s = tag_out_s.zero ? {DATA_WIDTH{1'b0}} : mem_rdata;

    // Only the owner of the returning read sees rvalid and new data.
    if (tag_out_s.valid) begin
      case (tag_out_s.owner)
        OWN_CPU: begin
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = rd_word_s;
        end
        OWN_HOST: begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = rd_word_s;
        end
        default: begin
          cpu_rvalid_d  = 1'b0;
          host_rvalid_d = 1'b0;
        end
      endcase
    end else begin
      cpu_rvalid_d  = 1'b0;
      host_rvalid_d = 1'b0;
    end
  end

  // State and registered outputs; all clear asynchronously in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q      <= {SW{1'b0}};
      stall_cnt_q   <= {CNT_WIDTH{1'b0}};
      addr_err_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= {DATA_WIDTH{1'b0}};
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      starve_q      <= starve_d;
      stall_cnt_q   <= stall_cnt_d;
      addr_err_q    <= addr_err_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign addr_err    = addr_err_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule : dmem_arbiter
